// File: rtl/matmul_sequencer_pkg.sv
// Shared types and sizing helpers for the systolic matrix issue sequencer.
package matmul_pkg;

  // Matmul-class opcodes as delivered by decode; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    WRITE_A = 3'd0,
    WRITE_B = 3'd1,
    WRITE_C = 3'd2,
    MATMUL  = 3'd3,
    READ_C  = 3'd4,
    STEP    = 3'd5
  } mm_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } mm_state_e;

  // Row index field carried by decode.
  typedef logic [3:0] mm_idx_t;

  // A full matmul pass through a DIM x DIM systolic array takes 3*DIM-2 steps.
  function automatic int steps_for(input int dim);
    return 3 * dim - 2;
  endfunction

  // Counter width able to hold 0..steps-1, never narrower than one bit.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Command, array-strobe and result signals between decode, the sequencer and
// the systolic array.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. Decode holds cmd_op/cmd_idx/cmd_high/cmd_wdata
// stable while cmd_valid is high and cmd_ready is low; the sequencer never
// drops or queues a command it has not accepted. stall mirrors valid & ~ready.
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int VLEN   = 4,
  parameter int DATA_W = 32
);

  // decode -> sequencer
  logic                   cmd_valid;
  logic                   cmd_ready;
  mm_op_e                 cmd_op;
  mm_idx_t                cmd_idx;
  logic                   cmd_high;
  logic [VLEN*DATA_W-1:0] cmd_wdata;
  logic                   stall;

  // sequencer -> array
  logic                   sa_load_a;
  logic                   sa_load_b;
  logic                   sa_load_c;
  logic                   sa_step;
  logic                   sa_read;
  mm_idx_t                sa_idx;
  logic                   sa_high;
  logic [VLEN*DATA_W-1:0] sa_wdata;
  logic [VLEN*DATA_W-1:0] sa_rdata;

  // results and status
  logic                   rd_valid;
  logic [VLEN*DATA_W-1:0] rd_data;
  logic                   done;
  logic                   cmd_err;
  mm_state_e              dbg_state;

  // Environment side: decode plus the array's read-data return.
  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_high, cmd_wdata, sa_rdata,
    input  cmd_ready, stall, sa_load_a, sa_load_b, sa_load_c, sa_step,
           sa_read, sa_idx, sa_high, sa_wdata, rd_valid, rd_data, done,
           cmd_err, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_high, cmd_wdata, sa_rdata,
    output cmd_ready, stall, sa_load_a, sa_load_b, sa_load_c, sa_step,
           sa_read, sa_idx, sa_high, sa_wdata, rd_valid, rd_data, done,
           cmd_err, dbg_state
  );

endinterface

// File: rtl/matmul_sequencer.sv
// Issue-side controller for the systolic matrix unit: accepts one command per
// handshake in IDLE, drives single-cycle array strobes, sequences the
// multi-cycle matmul run and the two-cycle readC round trip.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DIM    = 8,
  parameter int VLEN   = 4,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  matmul_sequencer_if.slave  bus
);

  localparam int STEPS = steps_for(DIM);
  localparam int CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  mm_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             cmd_bad;

  // An illegal opcode or an out-of-range row is flagged before any op decode.
  assign cmd_bad = (bus.cmd_op > STEP) || (int'(bus.cmd_idx) >= DIM);

  // Decode is only served in IDLE; everything else back-pressures.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.stall     = bus.cmd_valid & ~bus.cmd_ready;
  assign bus.dbg_state = state;

  // Single FSM with registered strobes; idx/high/wdata only move with a strobe
  // that uses them, so the array sees stable values between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.sa_load_a <= 1'b0;
      bus.sa_load_b <= 1'b0;
      bus.sa_load_c <= 1'b0;
      bus.sa_step   <= 1'b0;
      bus.sa_read   <= 1'b0;
      bus.sa_idx    <= '0;
      bus.sa_high   <= 1'b0;
      bus.sa_wdata  <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.done      <= 1'b0;
      bus.cmd_err   <= 1'b0;
    end else begin
      bus.sa_load_a <= 1'b0;
      bus.sa_load_b <= 1'b0;
      bus.sa_load_c <= 1'b0;
      bus.sa_step   <= 1'b0;
      bus.sa_read   <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.done      <= 1'b0;
      bus.cmd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_bad) begin
              bus.cmd_err <= 1'b1;
            end else begin
              case (bus.cmd_op)
                WRITE_A, WRITE_B, WRITE_C: begin
                  bus.sa_load_a <= (bus.cmd_op == WRITE_A);
                  bus.sa_load_b <= (bus.cmd_op == WRITE_B);
                  bus.sa_load_c <= (bus.cmd_op == WRITE_C);
                  bus.sa_idx    <= bus.cmd_idx;
                  bus.sa_high   <= bus.cmd_high;
                  bus.sa_wdata  <= bus.cmd_wdata;
                end
                MATMUL: begin
                  // First step goes out with the transition into RUN.
                  bus.sa_step <= 1'b1;
                  cnt         <= '0;
                  state       <= RUN;
                end
                READ_C: begin
                  bus.sa_read <= 1'b1;
                  bus.sa_idx  <= bus.cmd_idx;
                  bus.sa_high <= bus.cmd_high;
                  state       <= RD_REQ;
                end
                STEP: begin
                  bus.sa_step <= 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
        end
        RUN: begin
          // cnt numbers the step currently on the array; the last one ends the run.
          if (cnt == LAST_CNT) begin
            cnt      <= '0;
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            bus.sa_step <= 1'b1;
            cnt         <= cnt + CNT_W'(1);
          end
        end
        RD_REQ: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Array data is valid in this cycle, one cycle after sa_read.
          bus.rd_data  <= bus.sa_rdata;
          bus.rd_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed and random commands against a
// cycle-timeline reference model built from the command rules.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DIM    = 8;
  localparam int VLEN   = 4;
  localparam int DATA_W = 32;
  localparam int W      = VLEN * DATA_W;
  localparam int STEPS  = 3 * DIM - 2;
  localparam int N      = 4096;

  localparam logic [4:0] S_A    = 5'b10000;
  localparam logic [4:0] S_B    = 5'b01000;
  localparam logic [4:0] S_C    = 5'b00100;
  localparam logic [4:0] S_STEP = 5'b00010;
  localparam logic [4:0] S_RD   = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_sequencer_if #(.VLEN(VLEN), .DATA_W(DATA_W)) bus ();

  matmul_sequencer #(.DIM(DIM), .VLEN(VLEN), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference timeline ----------------
  logic [4:0]   exp_strb [N];
  bit           exp_done [N];
  bit           exp_err  [N];
  bit           exp_rdv  [N];
  bit           mm_start [N];
  bit           upd_iw   [N];
  bit           upd_w    [N];
  logic [3:0]   upd_idx  [N];
  bit           upd_high [N];
  logic [W-1:0] upd_wd   [N];
  logic [W-1:0] exp_q[$];

  int           busy_until = -1;
  logic [3:0]   h_idx  = '0;
  bit           h_high = 1'b0;
  logic [W-1:0] h_wd   = '0;
  logic [W-1:0] h_rd   = '0;
  int           mm_steps = 0;
  bit           chk_en = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  // Record everything a command accepted on edge k makes visible from cycle k on.
  function automatic void schedule(input int k, input int op3, input int idx,
                                   input bit high, input logic [W-1:0] wd,
                                   input logic [W-1:0] rdv);
    if (k + STEPS + 2 >= N) return;
    if (op3 > 5 || idx >= DIM) begin
      exp_err[k] = 1'b1;
    end else if (op3 <= 2) begin
      exp_strb[k] = (op3 == 0) ? S_A : (op3 == 1) ? S_B : S_C;
      upd_iw[k]   = 1'b1;
      upd_idx[k]  = 4'(idx);
      upd_high[k] = high;
      upd_w[k]    = 1'b1;
      upd_wd[k]   = wd;
    end else if (op3 == 3) begin
      for (int i = 0; i < STEPS; i++) exp_strb[k+i] = S_STEP;
      mm_start[k]        = 1'b1;
      exp_done[k+STEPS]  = 1'b1;
      busy_until         = k + STEPS - 1;
    end else if (op3 == 4) begin
      exp_strb[k]  = S_RD;
      upd_iw[k]    = 1'b1;
      upd_idx[k]   = 4'(idx);
      upd_high[k]  = high;
      exp_rdv[k+2] = 1'b1;
      exp_q.push_back(rdv);
      busy_until   = k + 1;
    end else begin
      exp_strb[k] = S_STEP;
    end
  endfunction

  // Reset discards all pending work and returns held values to zero.
  function automatic void reset_model();
    for (int j = cyc + 1; j < N; j++) begin
      exp_strb[j] = '0; exp_done[j] = 0; exp_err[j] = 0; exp_rdv[j] = 0;
      mm_start[j] = 0;  upd_iw[j] = 0;   upd_w[j] = 0;
    end
    busy_until = cyc;
    h_idx = '0; h_high = 1'b0; h_wd = '0; h_rd = '0;
    mm_steps = 0;
    exp_q.delete();
  endfunction

  // ---------------- per-cycle scoreboard ----------------
  always @(posedge clk) begin
    logic [4:0] obs_strb;
    int j;
    #2;
    if (chk_en) begin
      j = cyc;
      obs_strb = {bus.sa_load_a, bus.sa_load_b, bus.sa_load_c, bus.sa_step, bus.sa_read};
      chk("strobe", W'(obs_strb), W'(exp_strb[j]));
      chk("strobe_onehot", W'($countones(obs_strb) <= 1), W'(1));
      chk("done", W'(bus.done), W'(exp_done[j]));
      chk("cmd_err", W'(bus.cmd_err), W'(exp_err[j]));
      chk("rd_valid", W'(bus.rd_valid), W'(exp_rdv[j]));
      chk("cmd_ready", W'(bus.cmd_ready), W'(j > busy_until));
      chk("stall", W'(bus.stall), W'(bus.cmd_valid && !(j > busy_until)));
      if (upd_iw[j]) begin h_idx = upd_idx[j]; h_high = upd_high[j]; end
      if (upd_w[j])  h_wd = upd_wd[j];
      chk("sa_idx", W'(bus.sa_idx), W'(h_idx));
      chk("sa_high", W'(bus.sa_high), W'(h_high));
      chk("sa_wdata", bus.sa_wdata, h_wd);
      if (mm_start[j]) mm_steps = 0;
      if (bus.sa_step) mm_steps++;
      if (bus.done) chk("done_after_steps", W'(mm_steps), W'(STEPS));
      if (exp_rdv[j]) h_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("rd_data", bus.rd_data, h_rd);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input int op3, input int idx, input bit high,
                      input logic [W-1:0] wd, input logic [W-1:0] rdv,
                      output int acc_k);
    int waits = 0;
    acc_k = -1;
    @(negedge clk);
    bus.cmd_op    = mm_op_e'(op3[2:0]);
    bus.cmd_idx   = idx[3:0];
    bus.cmd_high  = high;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    while (acc_k < 0) begin
      @(posedge clk);
      #1;
      if (cyc - 1 > busy_until) begin
        acc_k = cyc;
        schedule(acc_k, op3, idx, high, wd, rdv);
        if (op3 == 4 && idx < DIM) bus.sa_rdata = rdv;
      end else begin
        waits++;
        if (waits > 200) begin
          chk("accept_timeout", W'(0), W'(1));
          bus.cmd_valid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k0, k1;
    logic [W-1:0] wd;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = WRITE_A;
    bus.cmd_idx   = '0;
    bus.cmd_high  = 1'b0;
    bus.cmd_wdata = '0;
    bus.sa_rdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", W'(bus.cmd_ready), W'(1));
    chk("rst_strobes", W'({bus.sa_load_a, bus.sa_load_b, bus.sa_load_c, bus.sa_step, bus.sa_read}), W'(0));
    chk("rst_flags", W'({bus.done, bus.cmd_err, bus.rd_valid}), W'(0));
    chk("rst_idx_high", W'({bus.sa_idx, bus.sa_high}), W'(0));
    chk("rst_data", bus.sa_wdata | bus.rd_data, W'(0));
    chk("rst_state", W'(bus.dbg_state), W'(IDLE));
    rst = 1'b0;
    chk_en = 1'b1;

    // Back-to-back writes
    send(0, 3, 1'b1, rand_w(), '0, k0);
    send(1, 7, 1'b0, rand_w(), '0, k1);
    chk("b2b_write_spacing", W'(k1 - k0), W'(1));
    idle(3);

    // Matmul with WRITE_C held behind it
    send(3, 0, 1'b0, '0, '0, k0);
    idle(4);
    send(2, 5, 1'b1, rand_w(), '0, k1);
    chk("held_write_c_latency", W'(k1 - k0), W'(STEPS + 1));
    idle(2);

    // READ_C with a command held during the read
    wd = {4{32'hA5A5A5A5}};
    send(4, 2, 1'b0, '0, wd, k0);
    send(0, 1, 1'b0, rand_w(), '0, k1);
    chk("held_after_read_latency", W'(k1 - k0), W'(3));
    idle(3);
    chk("read_result", bus.rd_data, wd);

    // Illegal op and out-of-range row
    send(7, 0, 1'b0, rand_w(), '0, k0);
    send(0, 9, 1'b1, rand_w(), '0, k1);
    idle(2);
    chk("illegal_state_idle", W'(bus.dbg_state), W'(IDLE));

    // Randomized commands
    for (int n = 0; n < 50; n++) begin
      int op3, idx;
      op3 = $urandom_range(0, 7);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      send(op3, idx, 1'($urandom_range(0, 1)), rand_w(), rand_w(), k0);
      idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset mid-run at step 5
    send(3, 0, 1'b0, '0, '0, k0);
    idle(1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_step", W'(bus.sa_step), W'(0));
    chk("midrun_rst_ready", W'(bus.cmd_ready), W'(1));
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    idle(22);
    send(5, 0, 1'b0, '0, '0, k0);
    idle(3);

    chk("rd_queue_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
